// File: rtl/softmax_in_serializer.sv
// Takes packed `Tout-lane words and emits them one element per cycle, dropping the
// padded tail lanes of each row's final word and reporting the signed row maximum.
`ifndef Tout
`define Tout 8
`endif
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 16
`endif
`ifndef log2Tout
`define log2Tout 3
`endif
`ifndef log2_CH
`define log2_CH 12
`endif
`ifndef Log2_Softmax_pixel
`define Log2_Softmax_pixel 12
`endif

module softmax_in_serializer (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [`log2_CH-`log2Tout-1:0]           CH_in_div_Tout,
    input  logic [`Log2_Softmax_pixel-1:0]          CH_in,
    input  logic                                    dat_in_vld,
    output logic                                    dat_in_rdy,
    input  logic [`Tout*`MAX_DAT_DW-1:0]            dat_in,
    input  logic                                    dat_out_rdy,
    output logic                                    dat_out_vld,
    output logic [`MAX_DAT_DW-1:0]                  dat_out,
    output logic                                    dat_out_last,
    output logic                                    row_max_vld,
    output logic [`MAX_DAT_DW-1:0]                  row_max
);
    localparam int TOUT = `Tout;
    localparam int DW   = `MAX_DAT_DW;
    localparam int LT   = `log2Tout;
    localparam int WCW  = `log2_CH - `log2Tout;
    localparam int CHW  = `Log2_Softmax_pixel;
    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    logic                     r_full;
    logic [TOUT*DW-1:0]       r_word;
    logic [LT-1:0]            r_lane_cnt;
    logic [WCW-1:0]           r_word_cnt;
    logic signed [DW-1:0]     r_running_max;
    logic signed [DW-1:0]     r_row_max;
    logic                     r_row_max_vld;

    logic [CHW-1:0]           w_ch_m1;
    logic [LT-1:0]            w_last_idx;
    logic                     w_final_word;
    logic                     w_lane_is_last;
    logic                     w_out_hs;
    logic                     w_word_done;
    logic                     w_row_done;
    logic                     w_in_hs;
    logic signed [DW-1:0]     w_lane_dat;
    logic signed [DW-1:0]     w_max_next;

    // Final word of a row only carries ((CH_in-1) mod Tout)+1 real lanes.
    assign w_ch_m1        = CH_in - 1'b1;
    assign w_final_word   = (r_word_cnt == CH_in_div_Tout - 1'b1);
    assign w_last_idx     = w_final_word ? LT'(w_ch_m1 % TOUT) : LT'(TOUT - 1);
    assign w_lane_is_last = (r_lane_cnt == w_last_idx);

    assign w_lane_dat     = r_word[r_lane_cnt*DW +: DW];
    assign w_out_hs       = r_full & dat_out_rdy;
    assign w_word_done    = w_out_hs & w_lane_is_last;
    assign w_row_done     = w_word_done & w_final_word;
    assign w_max_next     = (w_lane_dat > r_running_max) ? w_lane_dat : r_running_max;

    // Refill in the same cycle the last lane leaves, so words stream without bubbles.
    assign dat_in_rdy     = ~r_full | w_word_done;
    assign w_in_hs        = dat_in_vld & dat_in_rdy;

    assign dat_out_vld    = r_full;
    assign dat_out        = r_full ? w_lane_dat : '0;
    assign dat_out_last   = r_full & w_lane_is_last & w_final_word;
    assign row_max_vld    = r_row_max_vld;
    assign row_max        = r_row_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full     <= 1'b0;
            r_word     <= '0;
        end else if (w_in_hs) begin
            r_full     <= 1'b1;
            r_word     <= dat_in;
        end else if (w_word_done) begin
            r_full     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_word_cnt <= '0;
        end else if (w_out_hs) begin
            r_lane_cnt <= w_lane_is_last ? '0 : r_lane_cnt + 1'b1;
            if (w_lane_is_last)
                r_word_cnt <= w_final_word ? '0 : r_word_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_running_max <= MOST_NEG;
            r_row_max     <= '0;
            r_row_max_vld <= 1'b0;
        end else begin
            r_row_max_vld <= w_row_done;
            if (w_out_hs)
                r_running_max <= w_row_done ? MOST_NEG : w_max_next;
            if (w_row_done)
                r_row_max     <= w_max_next;
        end
    end

endmodule
